// File: rtl/mult_8_pp_gen.sv
// mult_8_pp_gen: captures operands and SEW, drives eight 8x8 byte multipliers in combiner lane/weight order.
module mult_8_pp_gen (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  sew,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        busy,
  output logic        cs_start,
  output logic [1:0]  cs_sew,
  output logic [15:0] mult_out_1,
  output logic [15:0] mult_out_2,
  output logic [15:0] mult_out_3,
  output logic [15:0] mult_out_4,
  output logic [15:0] mult_out_5,
  output logic [15:0] mult_out_6,
  output logic [15:0] mult_out_7,
  output logic [15:0] mult_out_8,
  output logic        pp_pass,
  output logic        done,
  output logic        illegal_sew
);
  typedef enum logic [1:0] {IDLE, ISSUE, PASS0, PASS1} state_t;
  state_t state, nxt;
  logic [3:0][7:0] a_q, b_q;
  logic [15:0] prod [8];
  logic [15:0] m_q [8];
  logic accept;
  assign accept = state == IDLE && start && sew != 2'b11;
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = IDLE;
    case (state)
      IDLE:    nxt = accept ? ISSUE : IDLE;
      ISSUE:   nxt = PASS0;
      PASS0:   nxt = cs_sew == 2'b10 ? PASS1 : IDLE;
      default: nxt = IDLE;
    endcase
  end
  always_comb begin
    busy = state != IDLE;
    cs_start = state == ISSUE;
    pp_pass = state == PASS1;
    done = state == PASS1 || (state == PASS0 && cs_sew != 2'b10);
  end
  // Products are computed for the coming state so they land registered in PASS0/PASS1.
  for (genvar k = 0; k < 8; k++) begin : g_pp
    logic [1:0] ia, ib;
    assign ia = cs_sew == 2'b01 ? 2'(2 * (k / 4) + k % 2) : 2'(k % 4);
    assign ib = cs_sew == 2'b01 ? 2'(2 * (k / 4) + (k / 2) % 2)
              : cs_sew == 2'b10 ? {nxt == PASS1, k >= 4} : 2'(k % 4);
    assign prod[k] = (nxt == PASS0 || nxt == PASS1) && (cs_sew != 2'b00 || k < 4)
                   ? {8'h00, a_q[ia]} * {8'h00, b_q[ib]} : 16'h0000;
  end
  always_ff @(posedge clk)
    if (reset) begin
      a_q <= '0;
      b_q <= '0;
      cs_sew <= 2'b00;
      illegal_sew <= 1'b0;
      m_q <= '{default: 16'h0000};
    end else begin
      illegal_sew <= state == IDLE && start && sew == 2'b11;
      m_q <= prod;
      if (accept) begin
        a_q <= op_a;
        b_q <= op_b;
        cs_sew <= sew;
      end
    end
  assign mult_out_1 = m_q[0];
  assign mult_out_2 = m_q[1];
  assign mult_out_3 = m_q[2];
  assign mult_out_4 = m_q[3];
  assign mult_out_5 = m_q[4];
  assign mult_out_6 = m_q[5];
  assign mult_out_7 = m_q[6];
  assign mult_out_8 = m_q[7];
endmodule

// File: doc/mult_8_pp_gen.md
# mult_8_pp_gen

Partial-product generator that sits directly upstream of the 8-bit carry-save combiner in the multiplier execution unit. It captures two 32-bit operands and a SEW code, slices them into bytes, and drives eight unsigned 8x8 byte multipliers. The eight registered 16-bit products are presented in the lane and byte-weight order the combiner expects, together with the start pulse and SEW code that launch it. 32-bit mode takes two product passes; 8- and 16-bit modes take one.

## Interface
- No parameters; all widths fixed (8x8 multipliers, 32-bit operands).
- clk  in  1  clock; single clock domain
- reset  in  1  synchronous, active-high
- start  in  1  request; sampled only in IDLE
- sew  in  2  00 = 4x8-bit, 01 = 2x16-bit, 10 = 1x32-bit, 11 = illegal
- op_a  in  32  multiplicand (unsigned)
- op_b  in  32  multiplier (unsigned)
- busy  out  1  high from the cycle after acceptance through the last product cycle
- cs_start  out  1  one-cycle pulse to the combiner's start input
- cs_sew  out  2  registered SEW for the combiner; valid while cs_start is high, held until the next acceptance
- mult_out_1 … mult_out_8  out  16 each  registered byte products
- pp_pass  out  1  0 = first or only pass, 1 = second pass in 32-bit mode
- done  out  1  pulse on the last product cycle
- illegal_sew  out  1  pulse when start is received with sew = 11

## Operation
- Notation: a[i] = op_a byte i; b[j] = op_b byte j (as captured). Products are unsigned a[i]*b[j], zero-extended to 16 bits.
- FSM states: IDLE, ISSUE, PASS0, PASS1.
- IDLE with start and sew != 11:
  - Capture op_a, op_b and sew.
  - Next state is ISSUE.
- IDLE with start and sew = 11:
  - Pulse illegal_sew the next cycle.
  - Stay in IDLE; no capture and no cs_start.
- ISSUE: cs_start = 1; next state is PASS0.
- PASS0 products by mode:
  - sew 00: mult_out_k = a[k-1]*b[k-1] for k = 1..4; mult_out_5..8 = 0.
  - sew 01, lane 0: m1 = a0*b0, m2 = a1*b0, m3 = a0*b1, m4 = a1*b1.
  - sew 01, lane 1: m5 = a2*b2, m6 = a3*b2, m7 = a2*b3, m8 = a3*b3.
  - sew 10: m1..m4 = a[0..3]*b0; m5..m8 = a[0..3]*b1.
  - Resulting weights in 32-bit mode: 0, 8, 16, 24, 8, 16, 24, 32 bits.
- PASS0 exit:
  - sew 10: go to PASS1.
  - Otherwise: done = 1 and go to IDLE.
- PASS1 (sew 10 only):
  - m1..m4 = a[0..3]*b2; m5..m8 = a[0..3]*b3; pp_pass = 1.
  - The combiner applies the extra 16-bit weight.
  - done = 1; go to IDLE.
- Outside PASS0/PASS1, mult_out_1..8 = 0 and pp_pass = 0.
- start is ignored in every state except IDLE; no queueing.
- Operands are used only from the capture registers, so input changes after acceptance have no effect.

## Timing
- Reset values:
  - State IDLE.
  - busy, cs_start, done, illegal_sew, pp_pass = 0.
  - cs_sew = 00.
  - All mult_out = 0.
  - Operand registers = 0.
- Cycle schedule, with start accepted in cycle T:
  - T+1: ISSUE; cs_start and cs_sew valid.
  - T+2: PASS0 products valid. This matches the combiner's state after it samples cs_start.
  - T+3: PASS1 products valid (32-bit mode only).
- Latency, start to last product: 2 cycles for 8/16-bit, 3 cycles for 32-bit.
- Next start is accepted in the cycle after done.
- Issue interval: 3 cycles for 8/16-bit, 4 cycles for 32-bit.
- busy is high for T+1..T+2 in 8/16-bit mode and T+1..T+3 in 32-bit mode.
- Reset in any cycle takes effect at the next edge:
  - FSM returns to IDLE and all outputs take their reset values.
  - A pending PASS1 never occurs.
  - Reset dominates a simultaneous start.
- Products are maximal at 0xFF*0xFF = 0xFE01; no overflow is possible in 16 bits.

## Test plan
- 8-bit: sew = 00, op_a = 0x04030201, op_b = 0x08070605, start at T.
  - Required: cs_start at T+1, cs_sew = 00.
  - At T+2: m1..m4 = 0x0005, 0x000C, 0x0015, 0x0020; m5..m8 = 0; done = 1.
- 16-bit: sew = 01, op_a = 0xFFFF0302, op_b = 0xFFFF0504.
  - At T+2: m1..m4 = 0x0008, 0x000C, 0x000A, 0x000F; m5..m8 = 0xFE01; done = 1.
- 32-bit: sew = 10, op_a = 0x04030201, op_b = 0x08070605.
  - At T+2, pp_pass = 0: m1..m4 = 5, 0xA, 0xF, 0x14; m5..m8 = 6, 0xC, 0x12, 0x18.
  - At T+3, pp_pass = 1: m1..m4 = 7, 0xE, 0x15, 0x1C; m5..m8 = 8, 0x10, 0x18, 0x20; done = 1.
  - busy is high for T+1..T+3.
- Start while busy and operand change after acceptance:
  - Stimulus: second start with different operands at T+1 and T+2 of a 32-bit op.
  - Required: the second start is ignored and products are unchanged.
  - A start at T+4 is accepted, with cs_start at T+5.
- Illegal SEW: sew = 11 with start at T.
  - Required: illegal_sew = 1 at T+1; no cs_start, busy or done; all mult_out = 0.
- Reset mid-operation: 32-bit op, reset asserted at T+2.
  - Required: at T+3 all outputs are 0 and the FSM is in IDLE, with no PASS1 products.
  - A new start at T+3 completes normally.
